// File: rtl/rw_responder_pkg.sv
// Shared constants for the read/write responder: FSM encoding and command direction.
package rw_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] WAITST = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ACKH   = 2'b11;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;
endpackage

// File: rtl/rw_responder_if.sv
// Requester <-> responder command bus with a 4-phase exec/ack handshake.
interface rw_responder_if #(parameter int DW = 8, parameter int AW = 4);
    logic          exec;
    logic          rd_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          busy;

    modport master (output exec, rd_wr, addr, wdata, input  ack, rdata, err, busy);
    modport slave  (input  exec, rd_wr, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/rw_responder_regfile.sv
// DEPTH x DW register array; the registered read port doubles as the bus rdata register.
module rw_regfile #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 12
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          we,
    input  logic          re,
    input  logic          zero,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[addr] <= wdata;
            // writes and rejected addresses both report zero read data
            if (we || zero) rdata <= '0;
            else if (re)    rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/rw_responder.sv
// Command target: captures a request in IDLE, waits WAIT cycles, accesses the array, then holds ack until exec drops.
module rw_responder
    import rw_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 12,
    parameter int WAIT  = 2
) (
    input  logic           clk,
    input  logic           reset,
    rw_responder_if.slave  bus
);
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          cmd_wr;
    logic          cmd_err;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          ack_q;
    logic          err_q;
    logic          addr_bad;
    logic          in_access;

    // one extra bit so DEPTH == 2**AW compares correctly
    assign addr_bad  = {1'b0, bus.addr} >= (AW+1)'(DEPTH);
    assign in_access = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_wr    <= RD;
            cmd_err   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.exec) begin
                    cmd_wr    <= bus.rd_wr;
                    cmd_addr  <= bus.addr;
                    cmd_wdata <= bus.wdata;
                    cmd_err   <= addr_bad;
                    // bad addresses pass through ACCESS without touching the array
                    if (addr_bad || WAIT == 0) state <= ACCESS;
                    else begin
                        state <= WAITST;
                        cnt   <= 4'(WAIT - 1);
                    end
                end
                WAITST: begin
                    if (cnt == 4'd0) state <= ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                ACCESS: begin
                    state <= ACKH;
                    ack_q <= 1'b1;
                    err_q <= cmd_err;
                end
                ACKH: if (!bus.exec) begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rw_regfile #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_regfile (
        .clk   (clk),
        .clr_n (reset),
        .we    (in_access && cmd_wr == WR && !cmd_err),
        .re    (in_access && cmd_wr == RD && !cmd_err),
        .zero  (in_access && cmd_err),
        .addr  (cmd_addr),
        .wdata (cmd_wdata),
        .rdata (bus.rdata)
    );

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_rw_responder.sv
// Bench for rw_responder: WAIT=2 instance (dut0) driven from a vector table and corner sequences, WAIT=0 instance (dut1) for back-to-back.
module tb_rw_responder;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] exec, rd_wr;
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];
    logic [1:0] ack, err, busy;
    logic [7:0] rdata [2];

    int total = 0;
    int passed = 0;

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    rw_responder_if #(.DW(8), .AW(4)) b0 ();
    rw_responder_if #(.DW(8), .AW(4)) b1 ();

    assign b0.exec = exec[0];  assign b0.rd_wr = rd_wr[0];
    assign b0.addr = addr[0];  assign b0.wdata = wdata[0];
    assign b1.exec = exec[1];  assign b1.rd_wr = rd_wr[1];
    assign b1.addr = addr[1];  assign b1.wdata = wdata[1];
    assign ack[0] = b0.ack;  assign err[0] = b0.err;  assign busy[0] = b0.busy;  assign rdata[0] = b0.rdata;
    assign ack[1] = b1.ack;  assign err[1] = b1.err;  assign busy[1] = b1.busy;  assign rdata[1] = b1.rdata;

    rw_responder #(.DW(8), .AW(4), .DEPTH(12), .WAIT(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    rw_responder #(.DW(8), .AW(4), .DEPTH(12), .WAIT(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One full handshake: raise exec, wait for ack (bounded), compare against the scoreboard,
    // optionally keep exec high for 'hold' cycles, then drop exec for one edge.
    task automatic txn(input int s, input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ee, input int elat, input int hold);
        exp_t e;
        int   lat;
        int   bad;
        @(negedge clk);
        exec[s] = 1'b1; rd_wr[s] = wr; addr[s] = a; wdata[s] = d;
        sb.push_back('{rdata: er, err: ee});
        @(posedge clk);
        #1;
        // post-capture changes must be ignored
        rd_wr[s] = ~wr; addr[s] = ~a; wdata[s] = ~d;
        chk("busy_after_capture", int'(busy[s]), 1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (ack[s]) lat = k;
        end
        chk("ack_latency", lat, elat);
        e = sb.pop_front();
        if (lat != 0) begin
            chk("rdata", int'(rdata[s]), int'(e.rdata));
            chk("err", int'(err[s]), int'(e.err));
        end
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (!ack[s] || !busy[s] || rdata[s] != e.rdata) bad++;
        end
        if (hold > 0) chk("ack_held_while_exec", bad, 0);
        exec[s] = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_drop", int'(ack[s]), 0);
        chk("idle_after_drop", int'(busy[s]), 0);
        chk("err_drop", int'(err[s]), 0);
        chk("rdata_kept", int'(rdata[s]), int'(e.rdata));
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b0, 3};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 3};
        vecs[2] = '{1'b0, 4'd4,  8'h00, 8'h00, 1'b0, 3};
        vecs[3] = '{1'b1, 4'd12, 8'h77, 8'h00, 1'b1, 1};
        vecs[4] = '{1'b0, 4'd12, 8'h00, 8'h00, 1'b1, 1};
        vecs[5] = '{1'b1, 4'd11, 8'h5A, 8'h00, 1'b0, 3};
        vecs[6] = '{1'b0, 4'd11, 8'h00, 8'h5A, 1'b0, 3};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b0, 3};
        vecs[8] = '{1'b1, 4'd15, 8'hFF, 8'h00, 1'b1, 1};
        vecs[9] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 3};

        exec = '0; rd_wr = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_ack",   int'(ack[s]),   0);
            chk("reset_err",   int'(err[s]),   0);
            chk("reset_rdata", int'(rdata[s]), 0);
            chk("reset_busy",  int'(busy[s]),  0);
        end
        reset = 1'b1;

        foreach (vecs[i])
            txn(0, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, 0);

        // exec held 10 cycles past ack, then a single low cycle and a fresh command
        txn(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, 3, 10);
        txn(0, 1'b1, 4'd1, 8'h11, 8'h00, 1'b0, 3, 0);
        txn(0, 1'b0, 4'd1, 8'h00, 8'h11, 1'b0, 3, 0);

        // reset while a write sits in WAITST
        txn(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, 3, 0);
        @(negedge clk);
        exec[0] = 1'b1; rd_wr[0] = 1'b1; addr[0] = 4'd5; wdata[0] = 8'h3C;
        @(posedge clk);
        #1;
        chk("waitst_busy", int'(busy[0]), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exec[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ack",   int'(ack[0]),   0);
        chk("rst_mid_err",   int'(err[0]),   0);
        chk("rst_mid_rdata", int'(rdata[0]), 0);
        chk("rst_mid_busy",  int'(busy[0]),  0);
        reset = 1'b1;
        txn(0, 1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 3, 0);
        txn(0, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 3, 0);

        // WAIT=0 instance: back-to-back write then read
        txn(1, 1'b1, 4'd0, 8'hFF, 8'h00, 1'b0, 1, 0);
        txn(1, 1'b0, 4'd0, 8'h00, 8'hFF, 1'b0, 1, 0);
        txn(1, 1'b0, 4'd12, 8'h00, 8'h00, 1'b1, 1, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
